// File: rtl/if_trace_recorder_pkg.sv
// Shared types for the IF trace recorder: FSM encodings, in-flight entry
// and completed trace record layouts, plus a saturating counter helper.
// Struct field widths follow the IFT_* defaults below; the recorder's width
// parameters default to the same values and must be kept in step with them.
package if_trace_recorder_pkg;

   localparam int IFT_ADDR_W = 32;
   localparam int IFT_DATA_W = 32;
   localparam int IFT_TIME_W = 32;
   localparam int IFT_SEQ_W  = 16;

   typedef enum logic {W_SLEEP, W_ACTIVE} win_state_e;
   typedef enum logic {R_IDLE, R_WAIT_GNT} req_state_e;

   typedef struct packed {
      logic [IFT_ADDR_W-1:0] addr;
      logic [IFT_TIME_W-1:0] if_start;
      logic [IFT_TIME_W-1:0] mem_start;
   } if_inflight_t;

   typedef struct packed {
      logic [IFT_SEQ_W-1:0]  seq;
      logic [IFT_ADDR_W-1:0] addr;
      logic [IFT_DATA_W-1:0] instr;
      logic [IFT_TIME_W-1:0] if_start;
      logic [IFT_TIME_W-1:0] mem_start;
      logic [IFT_TIME_W-1:0] t_end;
   } if_trace_record_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic show-ahead FIFO: head entry is always presented on rdata.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module trace_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr, rptr;
   logic [LW-1:0]    count;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == LW'(DEPTH));
   assign level   = count;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rptr];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= ptr_inc(wptr);
         if (do_pop)  rptr <= ptr_inc(rptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/if_trace_recorder.sv
// Passive instruction-fetch tracer. Tracks granted fetches in an in-flight
// queue, retires them on rvalid into a timestamped trace buffer drained by a
// valid/ready port. Drops on overflow are counted; protocol misuse is flagged.
module if_trace_recorder
   import if_trace_recorder_pkg::*;
#(
   parameter int ADDR_WIDTH      = IFT_ADDR_W,
   parameter int DATA_WIDTH      = IFT_DATA_W,
   parameter int TIME_WIDTH      = IFT_TIME_W,
   parameter int BUFFER_DEPTH    = 16,
   parameter int MAX_OUTSTANDING = 2,
   parameter int SEQ_WIDTH       = IFT_SEQ_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      if_busy,
   input  logic                      if_ready,
   input  logic                      instr_req,
   input  logic [ADDR_WIDTH-1:0]     instr_addr,
   input  logic                      instr_gnt,
   input  logic                      instr_rvalid,
   input  logic [DATA_WIDTH-1:0]     instr_rdata,
   output logic                      trace_valid,
   input  logic                      trace_ready,
   output logic [SEQ_WIDTH-1:0]      trace_seq,
   output logic [ADDR_WIDTH-1:0]     trace_addr,
   output logic [DATA_WIDTH-1:0]     trace_instr,
   output logic [TIME_WIDTH-1:0]     trace_if_start,
   output logic [TIME_WIDTH-1:0]     trace_mem_start,
   output logic [TIME_WIDTH-1:0]     trace_end,
   output logic [$clog2(BUFFER_DEPTH):0] buffer_level,
   output logic [15:0]               overflow_count,
   output logic                      protocol_error,
   output logic [TIME_WIDTH-1:0]     time_now
);

   localparam int QLW = $clog2(MAX_OUTSTANDING) + 1;

   logic [TIME_WIDTH-1:0] now;
   win_state_e            win_state;
   logic [TIME_WIDTH-1:0] win_start;
   req_state_e            req_state;
   logic [TIME_WIDTH-1:0] pend_start;
   logic [SEQ_WIDTH-1:0]  seq;

   logic                  grant;
   logic [TIME_WIDTH-1:0] grant_mem_start;
   logic                  if_open;
   if_inflight_t          q_in, q_head;
   logic                  q_full, q_empty, retire;
   logic [QLW-1:0]        q_level_unused;
   if_trace_record_t      rec, tb_head;
   logic                  tb_full, tb_empty, tb_pop, drop;
   logic                  err_req_drop, err_rv_empty, err_q_over;

   assign time_now = now;
   assign if_open  = if_busy | if_ready;

   // decode an accepted grant and which request-start time it carries
   always_comb begin
      grant           = 1'b0;
      grant_mem_start = now;
      err_req_drop    = 1'b0;
      case (req_state)
         R_IDLE:     grant = instr_req & instr_gnt;
         R_WAIT_GNT: begin
            grant           = instr_gnt;
            grant_mem_start = pend_start;
            err_req_drop    = ~instr_gnt & ~instr_req;
         end
         default:    grant = 1'b0;
      endcase
   end

   assign q_in.addr      = instr_addr;
   assign q_in.if_start  = (win_state == W_ACTIVE) ? win_start : now;
   assign q_in.mem_start = grant_mem_start;

   // retire happens before push, so a full queue still takes a same-cycle grant
   assign retire       = instr_rvalid & ~q_empty;
   assign err_rv_empty = instr_rvalid & q_empty;
   assign err_q_over   = grant & q_full & ~retire;

   trace_fifo #(.WIDTH($bits(if_inflight_t)), .DEPTH(MAX_OUTSTANDING)) u_inflight (
      .clk(clk), .rst(rst), .push(grant), .wdata(q_in), .pop(retire),
      .rdata(q_head), .full(q_full), .empty(q_empty), .level(q_level_unused)
   );

   assign rec.seq       = seq;
   assign rec.addr      = q_head.addr;
   assign rec.instr     = instr_rdata;
   assign rec.if_start  = q_head.if_start;
   assign rec.mem_start = q_head.mem_start;
   assign rec.t_end     = now;

   assign tb_pop = ~tb_empty & trace_ready;
   assign drop   = retire & tb_full & ~tb_pop;

   trace_fifo #(.WIDTH($bits(if_trace_record_t)), .DEPTH(BUFFER_DEPTH)) u_buffer (
      .clk(clk), .rst(rst), .push(retire), .wdata(rec), .pop(tb_pop),
      .rdata(tb_head), .full(tb_full), .empty(tb_empty), .level(buffer_level)
   );

   // head record fields read as zero while the buffer is empty
   assign trace_valid     = ~tb_empty;
   assign trace_seq       = tb_empty ? '0 : tb_head.seq;
   assign trace_addr      = tb_empty ? '0 : tb_head.addr;
   assign trace_instr     = tb_empty ? '0 : tb_head.instr;
   assign trace_if_start  = tb_empty ? '0 : tb_head.if_start;
   assign trace_mem_start = tb_empty ? '0 : tb_head.mem_start;
   assign trace_end       = tb_empty ? '0 : tb_head.t_end;

   // free-running cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) now <= '0;
      else     now <= now + 1'b1;
   end

   // IF window: remembers when the current fetch window opened
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_state <= W_SLEEP;
         win_start <= '0;
      end else if (grant) begin
         if (if_open) begin
            win_state <= W_ACTIVE;
            win_start <= now;
         end else begin
            win_state <= W_SLEEP;
         end
      end else if (win_state == W_SLEEP && if_open) begin
         win_state <= W_ACTIVE;
         win_start <= now;
      end
   end

   // request tracking: latch first req cycle while waiting for grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_state  <= R_IDLE;
         pend_start <= '0;
      end else begin
         case (req_state)
            R_IDLE: if (instr_req & ~instr_gnt) begin
               req_state  <= R_WAIT_GNT;
               pend_start <= now;
            end
            R_WAIT_GNT: if (instr_gnt | ~instr_req) req_state <= R_IDLE;
            default: req_state <= R_IDLE;
         endcase
      end
   end

   // sequence numbering, drop counting and sticky error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq            <= '0;
         overflow_count <= '0;
         protocol_error <= 1'b0;
      end else begin
         if (retire) seq <= seq + 1'b1;
         if (drop)   overflow_count <= sat_inc16(overflow_count);
         if (err_req_drop | err_rv_empty | err_q_over) protocol_error <= 1'b1;
      end
   end

endmodule

// File: doc/if_trace_recorder.md
Name: if_trace_recorder

Overview:
- Passive monitor on the instruction-fetch stage and instruction-memory port. Records one timestamped trace record per completed fetch.
- Pipelined successor of the single-outstanding IF tracer: tracks up to MAX_OUTSTANDING granted-but-unreturned fetches.
- Stores completed records in a FIFO trace buffer, drained through a valid/ready port.
- Counts records dropped on overflow and flags memory-protocol violations. Never stalls the core or memory.

Parameters:
- ADDR_WIDTH, 32: instruction address width.
- DATA_WIDTH, 32: instruction data width.
- TIME_WIDTH, 32: cycle-counter and timestamp width.
- BUFFER_DEPTH, 16: trace buffer entries; power of two, >=2.
- MAX_OUTSTANDING, 2: in-flight queue depth; 1..4.
- SEQ_WIDTH, 16: record sequence-number width.

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- if_busy  in  1  IF stage busy
- if_ready  in  1  IF stage ready for a new fetch
- instr_req  in  1  memory request
- instr_addr  in  ADDR_WIDTH  request address
- instr_gnt  in  1  memory grant
- instr_rvalid  in  1  read data valid
- instr_rdata  in  DATA_WIDTH  read data
- trace_valid  out  1  head record available
- trace_ready  in  1  consumer accepts head record
- trace_seq  out  SEQ_WIDTH  record sequence number
- trace_addr  out  ADDR_WIDTH  fetched address
- trace_instr  out  DATA_WIDTH  fetched instruction
- trace_if_start  out  TIME_WIDTH  IF window start time
- trace_mem_start  out  TIME_WIDTH  first cycle instr_req was high for this fetch
- trace_end  out  TIME_WIDTH  rvalid cycle
- buffer_level  out  $clog2(BUFFER_DEPTH)+1  occupied trace-buffer entries
- overflow_count  out  16  dropped records; saturates at 0xFFFF
- protocol_error  out  1  sticky violation flag
- time_now  out  TIME_WIDTH  cycle counter

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs 0; counter, sequence, FIFOs, in-flight queue and FSMs cleared.
  - Records in flight at reset are discarded silently.
- time_now:
  - Increments every clk; wraps modulo 2^TIME_WIDTH.
  - Timestamp arithmetic is unsigned and wraps; no wrap detection.
- Window FSM:
  - SLEEP -> ACTIVE when if_busy|if_ready; window_start <= time_now.
  - On each grant, the entry takes window_start. If if_busy|if_ready is still high, window_start <= time_now (back-to-back fetch); otherwise go to SLEEP.
  - A grant while in SLEEP uses time_now as if_start.
- Request FSM:
  - R_IDLE: req&gnt -> push entry with mem_start=time_now, stay in R_IDLE.
  - R_IDLE: req&!gnt -> latch mem_start=time_now, go to R_WAIT_GNT.
  - R_WAIT_GNT: gnt -> push entry with the latched mem_start, go to R_IDLE.
  - R_WAIT_GNT: req dropped without gnt -> protocol_error, return to R_IDLE.
- In-flight queue:
  - Entry = {addr, if_start, mem_start}.
  - Grant while queue full: entry not stored; protocol_error set.
- Retire on instr_rvalid:
  - Pop the oldest entry and add instr_rdata and trace_end=time_now.
  - Assign trace_seq = seq, then seq++ (wraps). seq increments for dropped records too, so gaps mark drops.
  - rvalid with queue empty: ignored; protocol_error set.
- Same-cycle rvalid and grant: retire first, then push. A full queue therefore accepts the grant.
- Trace buffer:
  - Show-ahead FIFO. Record retired at cycle t is visible on trace_* at t+1; trace_valid=1 when non-empty.
  - Pop when trace_valid&trace_ready.
  - Retire when full: if a pop occurs in the same cycle the record is stored; otherwise it is dropped and overflow_count increments (saturating).
- protocol_error: sticky until reset.

Decomposition:
- Add to ryuki_datatypes:
  - if_trace_record_t (seq, addr, instr, if_start, mem_start, end).
  - if_inflight_t.
  - Enum types for the window and request FSMs.
- One generic sub-module, trace_fifo (parametrised width/depth, show-ahead, full/empty/level). Instantiated twice: in-flight queue and trace buffer.

Test Plan:
- Reset, then if_ready at t=3, req&gnt addr 0x100 at t=3, rvalid rdata 0xDEADBEEF at t=5 -> trace_valid at t=6; seq 0, if_start 3, mem_start 3, end 5.
- req high t=10..12, gnt at t=12, rvalid at t=13 -> mem_start 10, end 13.
- MAX_OUTSTANDING=2: grants at t=20 and t=21 (0x200, 0x204), rvalids at t=22 and t=23 -> records in order; ends 22 and 23; no error.
- trace_ready held 0, BUFFER_DEPTH+3 fetches -> buffer_level=BUFFER_DEPTH, overflow_count=3, next drained seq after the stored ones shows a gap of 3.
- rvalid with nothing outstanding -> protocol_error=1 and remains 1; no record produced.
- rst asserted mid-fetch between gnt and rvalid -> outputs 0 immediately; rvalid after release is ignored as empty-queue rvalid, so protocol_error=1.
